// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS receive channel: bit-slip symbol alignment and 10b/8b decode
module tmds_channel_decoder #(
    parameter int CTRL_RUN_MIN   = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       clk_pixel,
    input  logic       rst_n_i,
    input  logic [9:0] raw_i,
    output logic [7:0] data_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int RUN_W  = (CTRL_RUN_MIN   > 1) ? $clog2(CTRL_RUN_MIN)   : 1;
    localparam int TMO_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int IDLE_W = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN_MIN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_TIMEOUT - 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         raw_q, win_q, win_d;
    logic [3:0]         offset_q, offset_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [1:0]         hold_q, hold_d;
    logic [7:0]         data_q, data_d;
    logic               de_q, de_d;
    logic [1:0]         ctrl_q, ctrl_d;

    logic               is_ctrl;
    logic [1:0]         tok_code;
    logic [19:0]        cat_sh;
    logic [7:0]         d_fix;
    logic [7:0]         dec;

    always_comb begin
        cat_sh = {raw_i, raw_q} >> offset_q;
        win_d  = cat_sh[9:0];
    end

    always_comb begin
        is_ctrl  = 1'b1;
        tok_code = 2'b00;
        case (win_q)
            10'h354: tok_code = 2'b00;
            10'h0AB: tok_code = 2'b01;
            10'h154: tok_code = 2'b10;
            10'h2AB: tok_code = 2'b11;
            default: is_ctrl  = 1'b0;
        endcase
    end

    always_comb begin
        d_fix  = win_q[9] ? ~win_q[7:0] : win_q[7:0];
        dec    = 8'h00;
        dec[0] = d_fix[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = win_q[8] ? (d_fix[i] ^ d_fix[i-1]) : ~(d_fix[i] ^ d_fix[i-1]);
        end
    end

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        run_cnt_d  = run_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        idle_cnt_d = idle_cnt_q;
        hold_d     = hold_q;
        case (state_q)
            ST_SEARCH: begin
                // After a slip the window is flushed before run/timeout counting restarts
                if (hold_q != 2'd0) begin
                    hold_d = hold_q - 2'd1;
                end else if (is_ctrl && (run_cnt_q == RUN_LAST)) begin
                    state_d    = ST_LOCKED;
                    run_cnt_d  = '0;
                    tmo_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    run_cnt_d = '0;
                    tmo_cnt_d = '0;
                    hold_d    = 2'd2;
                end else begin
                    if (!is_ctrl) begin
                        run_cnt_d = '0;
                    end else if (run_cnt_q != '1) begin
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                    end
                    if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (is_ctrl) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = ST_SEARCH;
                    idle_cnt_d = '0;
                    run_cnt_d  = '0;
                    tmo_cnt_d  = '0;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Output rules follow the next state so the unlock edge already blanks DE
    always_comb begin
        data_d = 8'h00;
        de_d   = 1'b0;
        ctrl_d = ctrl_q;
        if (state_d == ST_LOCKED) begin
            if (is_ctrl) begin
                ctrl_d = tok_code;
            end else begin
                de_d   = 1'b1;
                data_d = dec;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_SEARCH;
            raw_q      <= 10'h000;
            win_q      <= 10'h000;
            offset_q   <= 4'd0;
            run_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            idle_cnt_q <= '0;
            hold_q     <= 2'd0;
            data_q     <= 8'h00;
            de_q       <= 1'b0;
            ctrl_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            raw_q      <= raw_i;
            win_q      <= win_d;
            offset_q   <= offset_d;
            run_cnt_q  <= run_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            hold_q     <= hold_d;
            data_q     <= data_d;
            de_q       <= de_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign data_o   = data_q;
    assign de_o     = de_q;
    assign ctrl_o   = ctrl_q;
    assign locked_o = (state_q == ST_LOCKED);
    assign offset_o = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - bench for tmds_channel_decoder against a symbol-level reference model
module tb_tmds_channel_decoder;

    localparam int RUN_MIN = 8;
    localparam int S_TMO   = 32;
    localparam int L_TMO   = 64;

    logic       clk_pixel = 1'b0;
    logic       rst_n_i;
    logic [9:0] raw_i;
    logic [7:0] data_o;
    logic       de_o;
    logic [1:0] ctrl_o;
    logic       locked_o;
    logic [3:0] offset_o;

    int checks;
    int errors;

    tmds_channel_decoder #(
        .CTRL_RUN_MIN  (RUN_MIN),
        .SEARCH_TIMEOUT(S_TMO),
        .LOCK_TIMEOUT  (L_TMO)
    ) dut (
        .clk_pixel(clk_pixel),
        .rst_n_i  (rst_n_i),
        .raw_i    (raw_i),
        .data_o   (data_o),
        .de_o     (de_o),
        .ctrl_o   (ctrl_o),
        .locked_o (locked_o),
        .offset_o (offset_o)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Reference model state: one symbol of history, the aligned window, and the search/lock bookkeeping
    logic [9:0] m_raw, m_win;
    int         m_off, m_run, m_tmo, m_idle, m_hold;
    bit         m_lock;
    logic [7:0] m_data;
    logic       m_de;
    logic [1:0] m_ctrl;
    logic       bq[$];

    function automatic int token_of(input logic [9:0] v);
        logic [9:0] tab [4];
        tab = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int i = 0; i < 4; i++) if (tab[i] == v) return i;
        return -1;
    endfunction

    function automatic logic [7:0] tmds_dec(input logic [9:0] q);
        logic [7:0] d, x;
        d = q[9] ? ~q[7:0] : q[7:0];
        x = d ^ {d[6:0], 1'b0};
        if (!q[8]) x = ~x;
        return {x[7:1], d[0]};
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] v;
        do v = 10'($urandom); while (token_of(v) >= 0);
        return v;
    endfunction

    task automatic model_reset();
        m_raw = 10'h0; m_win = 10'h0; m_off = 0; m_run = 0; m_tmo = 0;
        m_idle = 0; m_hold = 0; m_lock = 0; m_data = 8'h0; m_de = 0; m_ctrl = 2'b0;
    endtask

    task automatic model_edge(input logic [9:0] w);
        int         c;
        logic [19:0] cat;
        logic [9:0] nwin;
        c    = token_of(m_win);
        cat  = {w, m_raw};
        nwin = 10'(cat >> m_off);
        if (!m_lock) begin
            if (m_hold > 0) begin
                m_hold--;
            end else if (c >= 0 && m_run == RUN_MIN - 1) begin
                m_lock = 1; m_run = 0; m_tmo = 0; m_idle = 0;
            end else if (m_tmo == S_TMO - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_tmo = 0; m_hold = 2;
            end else begin
                m_run = (c >= 0) ? m_run + 1 : 0;
                m_tmo++;
            end
        end else begin
            if (c >= 0) m_idle = 0;
            else if (m_idle == L_TMO - 1) begin
                m_lock = 0; m_idle = 0; m_run = 0; m_tmo = 0;
            end else m_idle++;
        end
        m_de = 0; m_data = 8'h00;
        if (m_lock) begin
            if (c >= 0) m_ctrl = c[1:0];
            else begin m_de = 1; m_data = tmds_dec(m_win); end
        end
        m_raw = w;
        m_win = nwin;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("model_data",   32'(data_o),   32'(m_data));
        chk("model_de",     32'(de_o),     32'(m_de));
        chk("model_ctrl",   32'(ctrl_o),   32'(m_ctrl));
        chk("model_locked", 32'(locked_o), 32'(m_lock));
        chk("model_offset", 32'(offset_o), 32'(m_off));
    endtask

    task automatic step(input logic [9:0] w);
        raw_i = w;
        @(posedge clk_pixel);
        model_edge(w);
        #1;
        check_model();
    endtask

    task automatic set_skew(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(1'($urandom));
    endtask

    task automatic send_sym(input logic [9:0] s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) bq.push_back(s[i]);
        while (bq.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
            step(w);
        end
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        raw_i   = 10'h0;
        model_reset();
        @(posedge clk_pixel);
        #1;
        rst_n_i = 1'b1;
        bq.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n_i = 1'b0;
        raw_i   = 10'h0;
        model_reset();
        #2;
        chk("reset_data",   32'(data_o),   32'h0);
        chk("reset_de",     32'(de_o),     32'h0);
        chk("reset_ctrl",   32'(ctrl_o),   32'h0);
        chk("reset_locked", 32'(locked_o), 32'h0);
        chk("reset_offset", 32'(offset_o), 32'h0);
        repeat (2) @(posedge clk_pixel);
        #1;
        rst_n_i = 1'b1;

        // Aligned stream of 10'h354 tokens, then a data word
        set_skew(0);
        for (int i = 0; i < 20; i++) send_sym(10'h354);
        chk("aligned_locked", 32'(locked_o), 32'h1);
        chk("aligned_offset", 32'(offset_o), 32'h0);
        chk("aligned_ctrl",   32'(ctrl_o),   32'h0);
        send_sym(10'h100);
        send_sym(rand_data());
        send_sym(rand_data());
        chk("aligned_de",   32'(de_o),   32'h1);
        chk("aligned_data", 32'(data_o), 32'h00);

        // Decode of specific windows while locked
        send_sym(10'h2FF);
        send_sym(10'h1FF);
        send_sym(10'h0AB);
        chk("dec_2ff_de",   32'(de_o),   32'h1);
        chk("dec_2ff_data", 32'(data_o), 32'hFE);
        send_sym(10'h354);
        chk("dec_1ff_data", 32'(data_o), 32'h01);
        send_sym(10'h354);
        chk("dec_0ab_de",   32'(de_o),   32'h0);
        chk("dec_0ab_ctrl", 32'(ctrl_o), 32'h1);

        // Lock loss after LOCK_TIMEOUT data symbols with no token
        for (int i = 1; i <= 70; i++) begin
            send_sym(rand_data());
            if (i == 65) chk("loss_still_locked", 32'(locked_o), 32'h1);
            if (i == 66) begin
                chk("loss_unlocked", 32'(locked_o), 32'h0);
                chk("loss_de",       32'(de_o),     32'h0);
            end
        end
        chk("loss_de_end", 32'(de_o),     32'h0);
        chk("loss_offset", 32'(offset_o), 32'h0);

        // Run of 7 tokens must not lock; run of 8 locks on the 8th window
        do_reset();
        for (int i = 0; i < 7; i++) send_sym(10'h154);
        for (int i = 0; i < 5; i++) send_sym(rand_data());
        chk("run7_nolock", 32'(locked_o), 32'h0);
        for (int i = 0; i < 9; i++) send_sym(10'h154);
        chk("run8_before", 32'(locked_o), 32'h0);
        send_sym(10'h154);
        chk("run8_locked", 32'(locked_o), 32'h1);
        chk("run8_ctrl",   32'(ctrl_o),   32'h2);

        // Stream skewed by 7 bits: search steps the offset until it locks at 7
        do_reset();
        set_skew(7);
        for (int n = 0; n < 4000 && !locked_o; n++) begin
            send_sym((n % 130 < 30) ? 10'h2AB : rand_data());
        end
        chk("rot7_locked", 32'(locked_o), 32'h1);
        chk("rot7_offset", 32'(offset_o), 32'h7);
        chk("rot7_ctrl",   32'(ctrl_o),   32'h3);

        // No tokens at all: offset keeps cycling through 9 -> 0
        do_reset();
        begin
            bit saw9, wrapped;
            saw9 = 0; wrapped = 0;
            for (int i = 0; i < 400; i++) begin
                step(10'h000);
                if (offset_o == 4'd9) saw9 = 1;
                if (saw9 && offset_o == 4'd0) wrapped = 1;
            end
            chk("wrap_seen",   32'(wrapped),  32'h1);
            chk("wrap_locked", 32'(locked_o), 32'h0);
        end

        // Async reset while locked at offset 5, then relock
        do_reset();
        set_skew(5);
        for (int n = 0; n < 1000 && !locked_o; n++) send_sym(10'h2AB);
        chk("skew5_locked", 32'(locked_o), 32'h1);
        chk("skew5_offset", 32'(offset_o), 32'h5);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("areset_data",   32'(data_o),   32'h0);
        chk("areset_de",     32'(de_o),     32'h0);
        chk("areset_ctrl",   32'(ctrl_o),   32'h0);
        chk("areset_locked", 32'(locked_o), 32'h0);
        chk("areset_offset", 32'(offset_o), 32'h0);
        model_reset();
        @(posedge clk_pixel);
        #1;
        rst_n_i = 1'b1;
        set_skew(5);
        for (int n = 0; n < 1000 && !locked_o; n++) send_sym(10'h2AB);
        chk("relock_locked", 32'(locked_o), 32'h1);
        chk("relock_offset", 32'(offset_o), 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
